control_unit: RTL
=================

# control_unit

Sequencing controller for the ProjectB datapath. Fetches 16-bit instructions from the instruction memory, decodes them, and drives the register file, data memory and the 3-bit ALU function select so each instruction completes as a fixed multi-cycle sequence. Sits directly upstream of the ALU: its `ALU_Sel` output is the ALU's `Sel` input, and its register-file read addresses choose the ALU's `A`/`B` operands.

## Interface
Parameters:
- `PC_W`, default 7: program counter width (instruction memory depth 2^PC_W).

Ports:
- `Clk`  in  1: system clock, rising edge.
- `ResetN`  in  1: asynchronous, active-low reset.
- `InstrIn`  in  16: instruction memory read data for `PC_Addr` (combinational read).
- `PC_Addr`  out  PC_W: instruction memory address.
- `D_Addr`  out  8: data memory address.
- `D_Wr`  out  1: data memory write enable.
- `RF_s`  out  1: register-file write mux; 1 = data memory, 0 = ALU `Q`.
- `RF_W_Addr`  out  4: register-file write address.
- `RF_W_en`  out  1: register-file write enable.
- `RF_Ra_Addr`  out  4: read port A address (feeds ALU `A`).
- `RF_Rb_Addr`  out  4: read port B address (feeds ALU `B`).
- `ALU_Sel`  out  3: ALU function select.
- `Halted`  out  1: high while in HALT.
- `StateOut`  out  4: current state encoding, debug only.

Decided: one clock; reset is asynchronous and active-low.

## Operation
- Instruction fields: `op=IR[15:12]`, `ra=IR[11:8]`, `rb=IR[7:4]`, `rq=IR[3:0]`, `addr=IR[7:0]`.
- Opcodes: 0000 NOOP; 0001 STORE `D[addr]<=RF[ra]`; 0010 LOAD `RF[ra]<=D[addr]`; 0011 ADD (Sel 1); 0100 SUB (Sel 2); 0101 HALT; 0110 XOR (Sel 4); 0111 OR (Sel 5); 1000 AND (Sel 6); 1001 INC `RF[rq]<=RF[ra]+1` (Sel 7). ALU ops write `RF[rq] <= RF[ra] op RF[rb]`. Opcodes 1010-1111 execute as NOOP.
- States: INIT, FETCH, DECODE, NOOP, STORE, LOAD_A, LOAD_B, ALU_OP, HALT.
- INIT -> FETCH unconditionally.
- FETCH: `IR <= InstrIn`, `PC <= PC+1` (mod 2^PC_W, 127 wraps to 0). -> DECODE.
- DECODE: next state from `op`; no enables asserted.
- NOOP, STORE, LOAD_B, ALU_OP -> FETCH. LOAD_A -> LOAD_B.
- HALT: self-loop until reset; PC and IR frozen.
- Outputs are Moore, decoded from state and IR:
  - `D_Addr=addr`, `RF_Ra_Addr=ra`, `RF_Rb_Addr=rb` at all times.
  - `RF_W_Addr = ra` when op=LOAD, else `rq`.
  - `D_Wr=1` only in STORE.
  - `RF_W_en=1` only in LOAD_B (`RF_s=1`) and ALU_OP (`RF_s=0`).
  - `ALU_Sel` carries the opcode's select only in ALU_OP, else 0.
  - `RF_s` is 0 outside LOAD_A/LOAD_B.
- Reset values: PC=0, IR=0, state INIT; hence every output 0 and `Halted=0`.

## Timing
- Per-instruction cycles, counted from FETCH: NOOP/STORE/ALU ops/undefined 3; LOAD 4; HALT enters at cycle 3 and stays.
- `InstrIn` must be valid for `PC_Addr` within the FETCH cycle; IR captures it on the FETCH->DECODE edge.
- LOAD: data memory read is synchronous. `D_Addr` is stable in LOAD_A; data is valid in LOAD_B, where the RF captures it on the closing edge.
- STORE/ALU writes commit on the edge that leaves the execute state. The RF write address and data must be stable for that whole cycle; read addresses come from IR, unchanged since DECODE.
- Reset asserted mid-instruction (any state, including between LOAD_A and LOAD_B): state->INIT, PC=0, IR=0, `D_Wr`/`RF_W_en` drop immediately (asynchronously), no partial write. First FETCH occurs 2 cycles after `ResetN` rises (INIT, then FETCH).
- After the wrap from PC 127 to 0, execution continues normally.

## Test plan
- Reset: hold `ResetN=0` → all outputs 0, `StateOut`=INIT. Release → FETCH with `PC_Addr=0` on the 2nd edge.
- LOAD 0x2A05 (`RF[10]<=D[0x05]`) → `D_Addr=0x05` in LOAD_A and LOAD_B. In LOAD_B: `RF_W_en=1`, `RF_s=1`, `RF_W_Addr=10`. FETCH resumes with PC incremented by 1.
- ADD 0x3123 → in ALU_OP: `ALU_Sel=1`, `RA=1`, `RB=2`, `RF_W_Addr=3`, `RF_W_en=1`, `RF_s=0`, 3 cycles total. Repeat for SUB/XOR/OR/AND/INC with Sel 2/4/5/6/7. Opcode 0xB → no enables, 3 cycles.
- STORE 0x1480 → `D_Wr=1` for exactly one cycle, `D_Addr=0x80`, `RA=4`, `RF_W_en=0` throughout.
- HALT 0x5000 → `Halted=1` and `PC_Addr` frozen for 20+ cycles. Reset restarts from PC 0.
- Load 127 NOOPs then an ADD at address 127 and a LOAD at address 0 → PC wraps 127→0. Separately, assert `ResetN=0` during LOAD_A → `RF_W_en` never pulses, state returns to INIT.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencing controller for the ProjectB datapath.
// Fetches a 16-bit instruction, decodes it and drives the register file, data memory and
// ALU function select for a fixed per-opcode sequence of cycles.
module control_unit #(
   parameter int unsigned PC_W = 7
) (
   input  logic            Clk,
   input  logic            ResetN,
   input  logic [15:0]     InstrIn,
   output logic [PC_W-1:0] PC_Addr,
   output logic [7:0]      D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_Addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [2:0]      ALU_Sel,
   output logic            Halted,
   output logic [3:0]      StateOut
);

   // Opcode map
   localparam logic [3:0] OpNoop  = 4'h0;
   localparam logic [3:0] OpStore = 4'h1;
   localparam logic [3:0] OpLoad  = 4'h2;
   localparam logic [3:0] OpAdd   = 4'h3;
   localparam logic [3:0] OpSub   = 4'h4;
   localparam logic [3:0] OpHalt  = 4'h5;
   localparam logic [3:0] OpXor   = 4'h6;
   localparam logic [3:0] OpOr    = 4'h7;
   localparam logic [3:0] OpAnd   = 4'h8;
   localparam logic [3:0] OpInc   = 4'h9;

   // StateOut exposes this encoding directly; StInit must stay 0 so reset drives it to 0
   typedef enum logic [3:0] {
      StInit   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StNoop   = 4'd3,
      StStore  = 4'd4,
      StLoadA  = 4'd5,
      StLoadB  = 4'd6,
      StAluOp  = 4'd7,
      StHalt   = 4'd8
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;

   logic [3:0]        op;
   logic [3:0]        ra;
   logic [3:0]        rb;
   logic [3:0]        rq;

   assign op = ir_q[15:12];
   assign ra = ir_q[11:8];
   assign rb = ir_q[7:4];
   assign rq = ir_q[3:0];

   // Execute state chosen by an opcode; the unused opcodes 1010-1111 behave as NOOP
   function automatic state_e exec_state(logic [3:0] opc);
      state_e s;
      case (opc)
         OpNoop:  s = StNoop;
         OpStore: s = StStore;
         OpLoad:  s = StLoadA;
         OpHalt:  s = StHalt;
         OpAdd, OpSub, OpXor, OpOr, OpAnd, OpInc: s = StAluOp;
         default: s = StNoop;
      endcase
      return s;
   endfunction

   // ALU function select for each arithmetic/logic opcode; 0 for everything else
   function automatic logic [2:0] alu_sel_of(logic [3:0] opc);
      logic [2:0] sel;
      case (opc)
         OpAdd:   sel = 3'd1;
         OpSub:   sel = 3'd2;
         OpXor:   sel = 3'd4;
         OpOr:    sel = 3'd5;
         OpAnd:   sel = 3'd6;
         OpInc:   sel = 3'd7;
         default: sel = 3'd0;
      endcase
      return sel;
   endfunction

   // State, program counter and instruction register; reset clears all three at once
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= StInit;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state sequencing; IR and PC only change on the FETCH->DECODE edge
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         StInit: begin
            state_d = StFetch;
         end
         StFetch: begin
            ir_d    = InstrIn;
            // Natural wrap at 2^PC_W
            pc_d    = pc_q + PC_W'(1);
            state_d = StDecode;
         end
         StDecode: begin
            state_d = exec_state(op);
         end
         StNoop, StStore, StLoadB, StAluOp: begin
            state_d = StFetch;
         end
         StLoadA: begin
            // Synchronous data memory: address presented here, data arrives in LOAD_B
            state_d = StLoadB;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   // Moore outputs decoded from the current state and the latched instruction
   always_comb begin
      D_Addr     = ir_q[7:0];
      RF_Ra_Addr = ra;
      RF_Rb_Addr = rb;
      // LOAD writes its ra field; every ALU op writes rq
      RF_W_Addr  = (op == OpLoad) ? ra : rq;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_en    = 1'b0;
      ALU_Sel    = 3'd0;
      Halted     = 1'b0;
      case (state_q)
         StStore: begin
            D_Wr = 1'b1;
         end
         StLoadA: begin
            // Select memory data early so the write mux is settled before LOAD_B
            RF_s = 1'b1;
         end
         StLoadB: begin
            RF_s    = 1'b1;
            RF_W_en = 1'b1;
         end
         StAluOp: begin
            RF_W_en = 1'b1;
            ALU_Sel = alu_sel_of(op);
         end
         StHalt: begin
            Halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign PC_Addr  = pc_q;
   assign StateOut = state_q;

endmodule
